// File: rtl/priority_decoder_6x64_seq.sv
// Sequenced 6-to-64 word-line decoder: each accepted index (or a broadcast) drives
// its registered word line for WL_CYCLES cycles, followed by GAP_CYCLES all-zero precharge cycles.
module priority_decoder_6x64_seq #(
   parameter int unsigned WL_CYCLES  = 2,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic        in_clk,
   input  logic        in_rst,
   input  logic        in_valid,
   input  logic [5:0]  in_data,
   input  logic        in_bcast,
   output logic        in_ready,
   output logic [63:0] out_data,
   output logic        out_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Counter reload values; the gap reload is only ever used when GAP_CYCLES is nonzero
   localparam logic [3:0] WL_LOAD  = 4'(WL_CYCLES - 1);
   localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

   state_t      state;
   state_t      state_next;
   logic [3:0]  count;
   logic [3:0]  count_next;
   logic [63:0] data_next;
   logic        valid_next;
   logic        accept;

   // Ready comes from registered state only; it is also held low while reset is asserted
   assign in_ready = (state == IDLE) && !in_rst;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state     <= IDLE;
         count     <= 4'd0;
         out_data  <= 64'd0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_next;
         count     <= count_next;
         out_data  <= data_next;
         out_valid <= valid_next;
      end
   end

   always_comb begin
      state_next = state;
      count_next = count;
      data_next  = out_data;
      valid_next = out_valid;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = DRIVE;
               count_next = WL_LOAD;
               valid_next = 1'b1;
               data_next  = in_bcast ? {64{1'b1}} : (64'd1 << in_data);
            end
         end
         DRIVE: begin
            if (count == 4'd0) begin
               // Word line drops on the same edge DRIVE is left
               data_next  = 64'd0;
               valid_next = 1'b0;
               if (GAP_CYCLES == 0) begin
                  state_next = IDLE;
                  count_next = 4'd0;
               end else begin
                  state_next = GAP;
                  count_next = GAP_LOAD;
               end
            end else begin
               count_next = count - 4'd1;
            end
         end
         GAP: begin
            data_next  = 64'd0;
            valid_next = 1'b0;
            if (count == 4'd0) begin
               state_next = IDLE;
            end else begin
               count_next = count - 4'd1;
            end
         end
         default: begin
            state_next = IDLE;
            count_next = 4'd0;
            data_next  = 64'd0;
            valid_next = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/priority_decoder_6x64_seq.md
PRIORITY_DECODER_6X64_SEQ -- requirements
Module: priority_decoder_6x64_seq

Interface
REQ-001 SHALL provide parameter WL_CYCLES, default 2, the number of cycles a selected word line is held high (legal 1..15).
REQ-002 SHALL provide parameter GAP_CYCLES, default 1, the number of all-zero precharge cycles after each drive (legal 0..15).
REQ-003 SHALL provide port in_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port in_rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL provide port in_valid, input, 1, request present.
REQ-006 SHALL provide port in_data, input, 6, word-line index to select (0..63).
REQ-007 SHALL provide port in_bcast, input, 1, when set with a request, select all 64 lines (global write/clear).
REQ-008 SHALL provide port in_ready, output, 1, block can accept a request this cycle.
REQ-009 SHALL provide port out_data, output, 64, registered word-line enables, one-hot or all-ones.
REQ-010 SHALL provide port out_valid, output, 1, high exactly while out_data is being driven.

Function
REQ-011 SHALL implement FSM states IDLE, DRIVE, GAP held in registers.
REQ-012 SHALL drive in_ready high only in IDLE, decoded from registered state (no combinational path from in_valid).
REQ-013 SHALL accept a request on a rising edge where in_valid and in_ready are both high; in_data/in_bcast sampled only then.
REQ-014 SHALL on accept load out_data with bit in_data set (all others 0), or 64'hFFFF_FFFF_FFFF_FFFF when in_bcast=1; in_bcast overrides in_data.
REQ-015 SHALL on accept enter DRIVE, set out_valid=1, and load a 4-bit counter with WL_CYCLES-1.
REQ-016 SHALL in DRIVE hold out_data and out_valid stable, decrement counter each cycle; at counter 0 go to GAP (counter loaded GAP_CYCLES-1) or, if GAP_CYCLES=0, to IDLE.
REQ-017 SHALL clear out_data to 0 and out_valid to 0 on the same edge DRIVE is left.
REQ-018 SHALL in GAP keep out_data=0, decrement counter, return to IDLE at counter 0.
REQ-019 SHALL give latency: accept at edge N -> out_data valid from edge N through edge N+WL_CYCLES; in_ready high again after edge N+WL_CYCLES+GAP_CYCLES.
REQ-020 SHALL ignore in_valid, in_data, in_bcast while not in IDLE; no request is queued or lost-and-reported.
REQ-021 SHALL never assert more than one out_data bit unless the active request had in_bcast=1.
REQ-022 SHALL be round-trip exact with priority_encoder_64x6: encoding a one-hot out_data returns the original in_data.

Reset
REQ-023 SHALL on in_rst=1 asynchronously force state IDLE, counter 0, out_data 0, out_valid 0, regardless of clock.
REQ-024 SHALL on reset mid-DRIVE or mid-GAP abandon the operation; in_ready high on the first edge after in_rst deasserts.
REQ-025 SHALL keep in_ready low while in_rst=1.

Verification
REQ-026 SHALL cover single select: defaults, in_data=6'd37 accepted -> out_data=1<<37 for 2 cycles, 1 zero cycle, then in_ready=1.
REQ-027 SHALL cover boundaries: in_data=0 -> out_data=64'h1; in_data=63 -> out_data=64'h8000_0000_0000_0000.
REQ-028 SHALL cover broadcast: in_bcast=1, in_data=5 -> out_data all-ones, out_valid=1 for WL_CYCLES cycles.
REQ-029 SHALL cover back-to-back: in_valid held high with 10 then 20 -> second accepted only after gap; never two bits high together.
REQ-030 SHALL cover reset mid-DRIVE: assert in_rst in 1st drive cycle -> out_data=0 immediately, in_ready=1 first edge after release.
REQ-031 SHALL cover WL_CYCLES=1, GAP_CYCLES=0: requests 3,4 continuously valid -> out_data 1<<3, then 0 (IDLE), then 1<<4.
